// File: rtl/bbox_min_max_pkg.sv
// bbox_min_max_pkg: shared image geometry defaults and scan state encoding
package bbox_min_max_pkg;
  localparam int BB_IMG_W = 320;
  localparam int BB_IMG_H = 240;
  localparam int BB_ADDR_W = 17;
  localparam int BB_COORD_W = 9;
  localparam int BB_RD_LAT = 1;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
endpackage

// File: rtl/bbox_min_max_if.sv
// bbox_min_max_if: control handshake, frame-buffer read port and bounding-box result
// master: control FSM / RAM side (drives start, ack, read_data)
// slave: scanner side (drives done, read_addr, x_min, x_max, y_min, y_max, found)
interface bbox_min_max_if
  import bbox_min_max_pkg::*;
#(
  parameter int ADDR_W = BB_ADDR_W,
  parameter int COORD_W = BB_COORD_W
);
  logic start;
  logic ack;
  logic done;
  logic read_data;
  logic found;
  logic [ADDR_W-1:0] read_addr;
  logic [COORD_W-1:0] x_min;
  logic [COORD_W-1:0] x_max;
  logic [COORD_W-1:0] y_min;
  logic [COORD_W-1:0] y_max;
  modport master (
    output start, ack, read_data,
    input done, read_addr, x_min, x_max, y_min, y_max, found
  );
  modport slave (
    input start, ack, read_data,
    output done, read_addr, x_min, x_max, y_min, y_max, found
  );
endinterface

// File: rtl/bbox_min_max_raster_counter.sv
// raster_counter: raster-order address with x/y coordinates, stops at the last pixel
// Ports: clk, reset (async, active-low), en (advance), clr (back to 0),
//   addr/x/y (registered position), last (addr is the final pixel)
module raster_counter #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int ADDR_W = 17,
  parameter int COORD_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  output logic [ADDR_W-1:0]  addr,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);
  logic eol;
  assign last = addr == ADDR_W'(IMG_W * IMG_H - 1);
  assign eol = x == COORD_W'(IMG_W - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset || clr) begin
      addr <= '0;
      x <= '0;
      y <= '0;
    end else if (en && !last) begin
      addr <= addr + 1'b1;
      x <= eol ? '0 : x + 1'b1;
      y <= eol ? y + 1'b1 : y;
    end
endmodule

// File: rtl/bbox_min_max.sv
// bbox_min_max: bounding box of all set pixels in the 1-bit frame buffer
// Ports: clk (25 MHz pixel clock), reset (async, active-low),
//   b (slave: start/ack/done handshake, read_addr/read_data RAM port,
//   x_min/x_max/y_min/y_max/found registered result)
module bbox_min_max
  import bbox_min_max_pkg::*;
#(
  parameter int IMG_W = BB_IMG_W,
  parameter int IMG_H = BB_IMG_H,
  parameter int ADDR_W = BB_ADDR_W,
  parameter int COORD_W = BB_COORD_W,
  parameter int RD_LAT = BB_RD_LAT
) (
  input logic clk,
  input logic reset,
  bbox_min_max_if.slave b
);
  state_t state;
  logic [1:0] drain_cnt;
  logic last, hit, found_acc, found_nx;
  logic [COORD_W-1:0] cx, cy, ax, ay;
  logic [COORD_W-1:0] x_min_acc, x_max_acc, y_min_acc, y_max_acc;
  logic [COORD_W-1:0] x_min_nx, x_max_nx, y_min_nx, y_max_nx;
  logic [COORD_W-1:0] px [RD_LAT];
  logic [COORD_W-1:0] py [RD_LAT];
  logic [RD_LAT-1:0] pv;
  raster_counter #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .COORD_W(COORD_W)
  ) u_rc (
    .clk(clk),
    .reset(reset),
    .en(state == SCAN),
    .clr(state == IDLE || state == DONE),
    .addr(b.read_addr),
    .x(cx),
    .y(cy),
    .last(last)
  );
  // x/y/valid delayed by the RAM latency so they line up with read_data
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pv <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        px[i] <= '0;
        py[i] <= '0;
      end
    end else begin
      pv[0] <= state == SCAN;
      px[0] <= cx;
      py[0] <= cy;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        px[i] <= px[i-1];
        py[i] <= py[i-1];
      end
    end
  assign ax = px[RD_LAT-1];
  assign ay = py[RD_LAT-1];
  assign hit = pv[RD_LAT-1] & b.read_data;
  assign x_min_nx = hit && ax < x_min_acc ? ax : x_min_acc;
  assign x_max_nx = hit && ax > x_max_acc ? ax : x_max_acc;
  assign y_min_nx = hit && ay < y_min_acc ? ay : y_min_acc;
  assign y_max_nx = hit && ay > y_max_acc ? ay : y_max_acc;
  assign found_nx = found_acc | hit;
  // the last aligned pixel arrives on the DRAIN->DONE edge, so results load from the *_nx values
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      drain_cnt <= '0;
      found_acc <= 1'b0;
      x_min_acc <= '0;
      x_max_acc <= '0;
      y_min_acc <= '0;
      y_max_acc <= '0;
      b.done <= 1'b0;
      b.found <= 1'b0;
      b.x_min <= '0;
      b.x_max <= '0;
      b.y_min <= '0;
      b.y_max <= '0;
    end else begin
      if (state == SCAN || state == DRAIN) begin
        found_acc <= found_nx;
        x_min_acc <= x_min_nx;
        x_max_acc <= x_max_nx;
        y_min_acc <= y_min_nx;
        y_max_acc <= y_max_nx;
      end
      case (state)
        IDLE: if (b.start) begin
          state <= SCAN;
          found_acc <= 1'b0;
          x_min_acc <= '1;
          x_max_acc <= '0;
          y_min_acc <= '1;
          y_max_acc <= '0;
        end
        SCAN: if (last) begin
          state <= DRAIN;
          drain_cnt <= '0;
        end
        DRAIN: if (drain_cnt == 2'(RD_LAT - 1)) begin
          state <= DONE;
          b.done <= 1'b1;
          b.found <= found_nx;
          b.x_min <= found_nx ? x_min_nx : '0;
          b.x_max <= found_nx ? x_max_nx : '0;
          b.y_min <= found_nx ? y_min_nx : '0;
          b.y_max <= found_nx ? y_max_nx : '0;
        end else drain_cnt <= drain_cnt + 1'b1;
        DONE: if (b.ack) begin
          state <= IDLE;
          b.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
